chacha_block_ctrl: RTL and testbench

Iterative ChaCha20 block-function engine built around four quarter-round datapaths. It sequences the 4x4 state through column and diagonal half-rounds. It then adds the initial state and presents one 512-bit keystream block over a valid/ready handshake. It sits between the key/nonce/counter source and the stream-XOR stage.

---
 rtl/chacha_pkg.sv | 23 ++
 rtl/chacha_quarterround.sv | 23 ++
 rtl/chacha_block_ctrl.sv | 102 ++++++++++
 tb/tb_chacha_block_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// chacha_pkg: shared ChaCha constants, index tables and FSM encoding
package chacha_pkg;
  localparam int WORD_W = 32;
  localparam int N_WORDS = 16;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_e;
  localparam word_t SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8, 4'd12},
    '{4'd1, 4'd5, 4'd9, 4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };
  localparam logic [3:0] DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8, 4'd13},
    '{4'd3, 4'd4, 4'd9, 4'd14}
  };
  function automatic word_t rotl(word_t x, int n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction
endpackage

// File: rtl/chacha_quarterround.sv
// chacha_quarterround: combinational ChaCha quarter-round
module chacha_quarterround
  import chacha_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);
  logic [31:0] a1, b1, c1, d1;
  assign a1 = a_i + b_i;
  assign d1 = rotl(d_i ^ a1, 16);
  assign c1 = c_i + d1;
  assign b1 = rotl(b_i ^ c1, 12);
  assign a_o = a1 + b1;
  assign d_o = rotl(d1 ^ a_o, 8);
  assign c_o = c1 + d_o;
  assign b_o = rotl(b1 ^ c_o, 7);
endmodule

// File: rtl/chacha_block_ctrl.sv
// chacha_block_ctrl: iterative ChaCha block engine with valid/ready keystream output
module chacha_block_ctrl
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20,
  parameter int CTR_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         busy
);
  state_e state_q, state_d;
  logic [CTR_W-1:0] rcnt_q, rcnt_d;
  word_t st_q [N_WORDS];
  word_t st_d [N_WORDS];
  word_t init_q [N_WORDS];
  word_t init_d [N_WORDS];
  word_t iw [N_WORDS];
  word_t hr [N_WORDS];
  word_t qi [4][4];
  word_t qo [4][4];
  logic out_valid_q, out_valid_d;
  logic [511:0] out_data_q, out_data_d;
  always_comb begin
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        qi[j][k] = st_q[rcnt_q[0] ? DIAG_IDX[j][k] : COL_IDX[j][k]];
  end
  for (genvar j = 0; j < 4; j++) begin : g_qr
    chacha_quarterround u_qr (
      .a_i(qi[j][0]), .b_i(qi[j][1]), .c_i(qi[j][2]), .d_i(qi[j][3]),
      .a_o(qo[j][0]), .b_o(qo[j][1]), .c_o(qo[j][2]), .d_o(qo[j][3])
    );
  end
  always_comb begin
    for (int i = 0; i < 4; i++) iw[i] = SIGMA[i];
    for (int i = 0; i < 8; i++) iw[4+i] = key[32*i +: 32];
    iw[12] = counter;
    for (int i = 0; i < 3; i++) iw[13+i] = nonce[32*i +: 32];
    hr = st_q;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        hr[rcnt_q[0] ? DIAG_IDX[j][k] : COL_IDX[j][k]] = qo[j][k];
    state_d = state_q;
    rcnt_d = rcnt_q;
    st_d = st_q;
    init_d = init_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: if (in_valid) begin
        st_d = iw;
        init_d = iw;
        rcnt_d = '0;
        state_d = ROUND;
      end
      ROUND: begin
        st_d = hr;
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == CTR_W'(ROUNDS - 1)) begin
          state_d = OUT;
          out_valid_d = 1'b1;
          for (int i = 0; i < N_WORDS; i++) out_data_d[32*i +: 32] = hr[i] + init_q[i];
        end
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q <= '0;
      st_q <= '{default: '0};
      init_q <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q <= rcnt_d;
      st_q <= st_d;
      init_q <= init_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_chacha_block_ctrl.sv
// tb_chacha_block_ctrl: scoreboard bench for the ChaCha block engine
module tb_chacha_block_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, in_valid, out_ready, in_valid8, out_ready8;
  logic [255:0] key;
  logic [31:0] counter;
  logic [95:0] nonce;
  logic in_ready, out_valid, busy, in_ready8, out_valid8, busy8;
  logic [511:0] out_data, out_data8;
  logic [31:0] qa, qb, qc, qd, qa_o, qb_o, qc_o, qd_o;
  int checks = 0;
  int errors = 0;
  logic [511:0] exp_q [$];
  chacha_block_ctrl #(.ROUNDS(20), .CTR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .counter(counter), .nonce(nonce), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  chacha_block_ctrl #(.ROUNDS(8), .CTR_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .key(key), .counter(counter), .nonce(nonce), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .busy(busy8)
  );
  chacha_quarterround u_qr (
    .a_i(qa), .b_i(qb), .c_i(qc), .d_i(qd),
    .a_o(qa_o), .b_o(qb_o), .c_o(qc_o), .d_o(qd_o)
  );
  function automatic logic [31:0] rl(logic [31:0] x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [127:0] qrf(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
    a = a + b; d = rl(d ^ a, 16);
    c = c + d; b = rl(b ^ c, 12);
    a = a + b; d = rl(d ^ a, 8);
    c = c + d; b = rl(b ^ c, 7);
    return {a, b, c, d};
  endfunction
  function automatic logic [511:0] ref_block(logic [255:0] k, logic [31:0] ctr, logic [95:0] n, int rounds);
    logic [31:0] x [16];
    logic [31:0] s [16];
    logic [127:0] r;
    logic [511:0] o;
    int ib, ic, id;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int h = 0; h < rounds; h++)
      for (int j = 0; j < 4; j++) begin
        ib = (h % 2 == 0) ? j + 4 : 4 + (j + 1) % 4;
        ic = (h % 2 == 0) ? j + 8 : 8 + (j + 2) % 4;
        id = (h % 2 == 0) ? j + 12 : 12 + (j + 3) % 4;
        r = qrf(x[j], x[ib], x[ic], x[id]);
        x[j] = r[127:96]; x[ib] = r[95:64]; x[ic] = r[63:32]; x[id] = r[31:0];
      end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
    return o;
  endfunction
  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(logic [255:0] k, logic [31:0] c, logic [95:0] n);
    @(negedge clk);
    key = k; counter = c; nonce = n; in_valid = 1'b1;
    chk("in_ready_at_request", in_ready, 1);
    exp_q.push_back(ref_block(k, c, n, 20));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_out(string tag);
    int lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 100);
    chk({tag, "_latency"}, lat, 20);
    chk({tag, "_data"}, out_data, exp_q.pop_front());
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("handshake_out_valid", out_valid, 0);
    chk("handshake_in_ready", in_ready, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [255:0] rk;
    logic [95:0] n232, n242;
    logic [511:0] held;
    int lat;
    for (int i = 0; i < 32; i++) rk[8*i +: 8] = 8'(i);
    n232 = {32'h00000000, 32'h4a000000, 32'h09000000};
    n242 = {32'h00000000, 32'h4a000000, 32'h00000000};
    rst_n = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0; out_ready8 = 1'b1;
    key = '0; counter = '0; nonce = '0;
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst8_out_valid", out_valid8, 0);
    chk("qr_a", qa_o, 32'hea2a92f4);
    chk("qr_b", qb_o, 32'hcb1cf8ce);
    chk("qr_c", qc_o, 32'h4581472e);
    chk("qr_d", qd_o, 32'h5881c4bb);
    @(negedge clk);
    rst_n = 1'b1;
    send(rk, 32'd1, n232);
    chk("round_busy", busy, 1);
    chk("round_in_ready", in_ready, 0);
    wait_out("rfc232");
    chk("rfc232_w0", out_data[31:0], 32'he4e7f110);
    chk("rfc232_w1", out_data[63:32], 32'h15593bd1);
    chk("rfc232_w15", out_data[511:480], 32'h4e3c50a2);
    held = out_data;
    in_valid = 1'b1;
    counter = 32'd7;
    repeat (50) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, held);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_out();
    @(posedge clk);
    #1 chk("bp_no_ghost_job", busy, 0);
    out_ready = 1'b1;
    send(rk, 32'd1, n242);
    wait_out("b2b_first");
    release_out();
    send(rk, 32'd2, n242);
    wait_out("b2b_second");
    release_out();
    out_ready = 1'b0;
    send(rk, 32'd1, n232);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    void'(exp_q.pop_front());
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    repeat (25) @(posedge clk);
    #1 chk("midrst_no_block", out_valid, 0);
    send(rk, 32'd1, n232);
    wait_out("after_rst");
    release_out();
    @(negedge clk);
    key = '0; counter = '0; nonce = '0; in_valid8 = 1'b1;
    chk("r8_in_ready", in_ready8, 1);
    exp_q.push_back(ref_block('0, '0, '0, 8));
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid8 && lat < 100);
    chk("r8_latency", lat, 8);
    chk("r8_data", out_data8, exp_q.pop_front());
    @(posedge clk);
    #1 chk("r8_in_ready_after", in_ready8, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
